// File: rtl/lzd_div_if.sv
// Operand/result bundle for lzd_div_iter: master supplies operands and
// leading-zero counts, slave returns busy/done status and the result.
interface lzd_div_if #(
    parameter int WIDTH = 64
);
    localparam int CW = $clog2(WIDTH);

    logic             Start;
    logic             Flush;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] D;
    logic [CW-1:0]    NZeros;
    logic             NAllZero;
    logic [CW-1:0]    DZeros;
    logic             DAllZero;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Rem;
    logic             DivByZero;

    modport master (
        output Start, Flush, N, D, NZeros, NAllZero, DZeros, DAllZero,
        input  Busy, Done, Q, Rem, DivByZero
    );

    modport slave (
        input  Start, Flush, N, D, NZeros, NAllZero, DZeros, DAllZero,
        output Busy, Done, Q, Rem, DivByZero
    );
endinterface

// File: rtl/lzd_div_iter.sv
// Iterative restoring unsigned divider. With LZD_DIV_EARLY_OUT_EN defined it uses the
// upstream leading-zero counts to pre-align D and early-out; otherwise a fixed WIDTH-step loop.
module lzd_div_iter #(
    parameter int WIDTH = 64
) (
    input  logic     clk,
    input  logic     reset,
    lzd_div_if.slave io
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] n_r, d_r;
    logic [WIDTH-1:0] r, dsh, wq;
    logic [CW:0]      cnt;
    logic             dbz_w;
    logic [WIDTH-1:0] q_r, rem_r;
    logic             dbz_r;

    logic             accept, early, show, ge, bo;
    logic [WIDTH:0]   cmp_a, diff;
    logic [WIDTH-1:0] r_nx;
    logic             unused_bits;

`ifdef LZD_DIV_EARLY_OUT_EN
    logic [CW-1:0] nz_r, dz_r, shift;

    assign shift       = dz_r - nz_r;
    assign early       = io.DAllZero | io.NAllZero | (io.NZeros > io.DZeros);
    assign cmp_a       = {1'b0, r};
    assign unused_bits = diff[WIDTH];
`else
    assign early       = 1'b0;
    // Partial remainder {r, wq} shifted left by one before the trial subtract.
    assign cmp_a       = {r, wq[WIDTH-1]};
    assign unused_bits = ^{diff[WIDTH], io.NZeros, io.DZeros, io.NAllZero};
`endif

    assign accept = (state == IDLE) && io.Start && !io.Flush;

    // Extra borrow bit keeps the compare correct even when D=0 lets cmp_a use its top bit.
    assign {bo, diff} = {1'b0, cmp_a} - {2'b0, dsh};
    assign ge         = ~bo;
    assign r_nx       = ge ? diff[WIDTH-1:0] : cmp_a[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = early ? DONE : NORM;
            NORM:    state_nx = ITER;
            ITER:    if (cnt == (CW+1)'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (io.Flush && (state != IDLE)) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_r   <= '0;
            d_r   <= '0;
            r     <= '0;
            dsh   <= '0;
            wq    <= '0;
            cnt   <= '0;
            dbz_w <= 1'b0;
            q_r   <= '0;
            rem_r <= '0;
            dbz_r <= 1'b0;
`ifdef LZD_DIV_EARLY_OUT_EN
            nz_r  <= '0;
            dz_r  <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    n_r   <= io.N;
                    d_r   <= io.D;
                    dbz_w <= io.DAllZero;
                    r     <= io.N;
                    wq    <= io.DAllZero ? '1 : '0;
`ifdef LZD_DIV_EARLY_OUT_EN
                    nz_r  <= io.NZeros;
                    dz_r  <= io.DZeros;
`endif
                end
                NORM: begin
`ifdef LZD_DIV_EARLY_OUT_EN
                    r   <= n_r;
                    wq  <= '0;
                    dsh <= d_r << shift;
                    cnt <= {1'b0, shift} + (CW+1)'(1);
`else
                    r   <= '0;
                    wq  <= n_r;
                    dsh <= d_r;
                    cnt <= (CW+1)'(WIDTH);
`endif
                end
                ITER: begin
                    r   <= r_nx;
                    wq  <= {wq[WIDTH-2:0], ge};
                    cnt <= cnt - (CW+1)'(1);
`ifdef LZD_DIV_EARLY_OUT_EN
                    dsh <= dsh >> 1;
`endif
                end
                // Result becomes the held value only if the strobe was not flushed.
                DONE: if (!io.Flush) begin
                    q_r   <= wq;
                    rem_r <= r;
                    dbz_r <= dbz_w;
                end
                default: ;
            endcase
        end
    end

    assign show         = (state == DONE) && !io.Flush;
    assign io.Busy      = (state == NORM) || (state == ITER);
    assign io.Done      = show;
    assign io.Q         = show ? wq    : q_r;
    assign io.Rem       = show ? r     : rem_r;
    assign io.DivByZero = show ? dbz_w : dbz_r;
endmodule

// File: tb/tb_lzd_div_iter.sv
// Bench for lzd_div_iter at WIDTH=8: vector table plus hand sequences for ignored
// Start, Flush mid-operation, Flush on the result cycle and Flush+Start in IDLE.
module tb_lzd_div_iter;
    localparam int W  = 8;
    localparam int CW = $clog2(W);
    localparam int NV = 10;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lzd_div_if #(.WIDTH(W)) io ();
    lzd_div_iter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .io(io));

    typedef struct { logic [W-1:0] q, rem; logic dbz; int at; } exp_t;
    typedef struct { logic [W-1:0] n, d, q, rem; logic dbz; } vec_t;

    exp_t sb[$];
    vec_t vt[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int lzc(input logic [W-1:0] x);
        for (int i = W - 1; i >= 0; i--) if (x[i]) return W - 1 - i;
        return 0;
    endfunction

    function automatic int lat(input logic [W-1:0] n, input logic [W-1:0] d);
`ifdef LZD_DIV_EARLY_OUT_EN
        if (d == 0 || n == 0 || lzc(n) > lzc(d)) return 1;
        return 3 + lzc(d) - lzc(n);
`else
        return 2 + W;
`endif
    endfunction

    task automatic at_cycle(input int k);
        while (cyc < k) begin @(posedge clk); #1; end
    endtask

    task automatic wait_neg(input int k);
        do @(negedge clk); while (cyc < k);
    endtask

    task automatic set_ops(input logic [W-1:0] n, input logic [W-1:0] d);
        io.N        = n;
        io.D        = d;
        io.NZeros   = CW'(lzc(n));
        io.DZeros   = CW'(lzc(d));
        io.NAllZero = (n == 0);
        io.DAllZero = (d == 0);
    endtask

    // One-cycle Start; flush_nx drives Flush during the following cycle.
    task automatic drive(input logic [W-1:0] n, d, eq, er, input logic ed,
                         input bit push, input bit flush_nx, output int t);
        @(posedge clk); #1;
        set_ops(n, d);
        io.Start = 1'b1;
        io.Flush = 1'b0;
        t = cyc;
        if (push) sb.push_back('{q: eq, rem: er, dbz: ed, at: t + lat(n, d)});
        @(posedge clk); #1;
        io.Start = 1'b0;
        io.Flush = flush_nx;
    endtask

    task automatic wait_idle();
        int lim = cyc + 3 * W + 10;
        while (sb.size() != 0 && cyc < lim) @(negedge clk);
        if (sb.size() != 0) begin
            ntests++;
            nfail++;
            $display("FAIL timeout: %0d result(s) pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && io.Done) begin
            if (sb.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL spurious_done: got Done with Q=%0h, expected no Done", io.Q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q", io.Q, e.q);
                chk("rem", io.Rem, e.rem);
                chk("dbz", io.DivByZero, e.dbz);
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int t, l;
        vt[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vt[1] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
        vt[2] = '{8'h2A,  8'd0,   8'hFF,  8'h2A,  1'b1};
        vt[3] = '{8'hFF,  8'd1,   8'hFF,  8'd0,   1'b0};
        vt[4] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        vt[5] = '{8'd200, 8'd200, 8'd1,   8'd0,   1'b0};
        vt[6] = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0};
        vt[7] = '{8'd9,   8'd4,   8'd2,   8'd1,   1'b0};
        vt[8] = '{8'd1,   8'd1,   8'd1,   8'd0,   1'b0};
        vt[9] = '{8'd250, 8'd16,  8'd15,  8'd10,  1'b0};

        reset    = 1'b1;
        io.Start = 1'b0;
        io.Flush = 1'b0;
        set_ops('0, '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_q", io.Q, 0);
        chk("rst_rem", io.Rem, 0);
        chk("rst_busy", io.Busy, 0);
        chk("rst_done", io.Done, 0);
        chk("rst_dbz", io.DivByZero, 0);

        for (int i = 0; i < NV; i++) begin
            l = lat(vt[i].n, vt[i].d);
            drive(vt[i].n, vt[i].d, vt[i].q, vt[i].rem, vt[i].dbz, 1'b1, 1'b0, t);
            wait_neg(t + 1);
            chk($sformatf("busy_v%0d", i), io.Busy, l != 1);
            wait_idle();
        end

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] n, d;
            n = W'($urandom);
            d = (i == 3) ? '0 : W'($urandom_range(1, 40));
            drive(n, d, (d == 0) ? '1 : n / d, (d == 0) ? n : n % d, d == 0, 1'b1, 1'b0, t);
            wait_idle();
        end

        // Start while busy must be ignored; Busy profile checked cycle by cycle.
        l = lat(8'd100, 8'd7);
        drive(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1, 1'b0, t);
        for (int k = 1; k <= l; k++) begin
            if (k == 3) begin at_cycle(t + 3); set_ops(8'hFF, 8'h01); io.Start = 1'b1; end
            if (k == 4) begin at_cycle(t + 4); io.Start = 1'b0; end
            wait_neg(t + k);
            chk($sformatf("busy_c%0d", k), io.Busy, k < l);
        end
        wait_idle();

        // Flush mid-operation: no Done, prior result held, fresh Start works.
        drive(8'hFF, 8'd1, '0, '0, 1'b0, 1'b0, 1'b0, t);
        at_cycle(t + 4); io.Flush = 1'b1;
        at_cycle(t + 5); io.Flush = 1'b0;
        wait_neg(t + 5);
        chk("flush_busy", io.Busy, 0);
        chk("flush_q", io.Q, 14);
        chk("flush_rem", io.Rem, 2);
        drive(8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 1'b1, 1'b0, t);
        wait_idle();

        // Flush on the cycle after Start (the result cycle for an early-out).
        drive(8'd5, 8'd9, '0, '0, 1'b0, 1'b0, 1'b1, t);
        wait_neg(t + 1);
        chk("fdone_done", io.Done, 0);
        chk("fdone_q", io.Q, 2);
        chk("fdone_rem", io.Rem, 1);
        at_cycle(t + 2); io.Flush = 1'b0;
        wait_neg(t + 2);
        chk("fdone_busy", io.Busy, 0);
        chk("fdone_q2", io.Q, 2);
        chk("fdone_rem2", io.Rem, 1);

        // Flush and Start together in IDLE: Start dropped.
        at_cycle(cyc + 1);
        set_ops(8'd100, 8'd7);
        io.Start = 1'b1;
        io.Flush = 1'b1;
        t = cyc;
        at_cycle(t + 1);
        io.Start = 1'b0;
        io.Flush = 1'b0;
        wait_neg(t + 1);
        chk("fs_busy", io.Busy, 0);
        chk("fs_done", io.Done, 0);
        wait_neg(t + 2);
        chk("fs_busy2", io.Busy, 0);
        chk("fs_q", io.Q, 2);

        repeat (3 * W) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
